// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch
// ---------------
// Generic pipeline-stage register with a valid/ready handshake and a
// two-entry skid buffer. It replaces the fixed IF/ID, ID/EX, EX/MEM and
// MEM/WB latches; the caller packs the stage-specific fields into the opaque
// data and control buses. Because in_ready depends only on the skid register
// and flush, there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   DW         data bus width
//   CW         control bus width (all-zero control = NOP / bubble)
//   FLUSH_DATA 1: flush also zeroes the data registers, 0: data holds
//   CNT_W      stall counter width (only used with PIPE_SKID_STATS_EN)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; clears every register
//   flush      drops held entries and this cycle's input
//   in_valid   upstream entry present
//   in_ready   stage can accept this cycle
//   in_data    upstream data
//   in_ctrl    upstream control
//   out_valid  stage holds an entry (registered)
//   out_ready  downstream accepts
//   out_data   main-register data (registered)
//   out_ctrl   main-register control, zero while out_valid is low
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
//              (present only when PIPE_SKID_STATS_EN is defined)
//
// Optional feature macro: PIPE_SKID_STATS_EN

module pipe_skid_latch #(
    parameter int DW         = 32,
    parameter int CW         = 16,
    parameter int FLUSH_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [CW-1:0]    in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CW-1:0]    out_ctrl
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Encoding is {s_valid, m_valid}; (1,0) cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t          state;
    logic [DW-1:0]   m_data;
    logic [CW-1:0]   m_ctrl;
    logic [DW-1:0]   s_data;
    logic [CW-1:0]   s_ctrl;
    logic            m_valid;
    logic            s_valid;
    logic            in_xfer;
    logic            out_xfer;

    assign m_valid  = (state != EMPTY);
    assign s_valid  = (state == SKID);
    assign in_ready = !s_valid && !flush;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = m_valid && out_ready;

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : '0;

    // Reset outranks flush, flush outranks all handshake activity. The skid
    // entry always drains into main before any newer input is taken, which
    // keeps entries in arrival order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            m_data <= '0;
            m_ctrl <= '0;
            s_data <= '0;
            s_ctrl <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            s_ctrl <= '0;
            if (FLUSH_DATA != 0) begin
                m_data <= '0;
                s_data <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        m_data <= in_data;
                        m_ctrl <= in_ctrl;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (out_xfer && in_xfer) begin
                        m_data <= in_data;
                        m_ctrl <= in_ctrl;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end else if (in_xfer) begin
                        s_data <= in_data;
                        s_ctrl <= in_ctrl;
                        state  <= SKID;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        m_data <= s_data;
                        m_ctrl <= s_ctrl;
                        state  <= FULL;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    // Counts backpressured cycles; saturates rather than wrapping and is
    // deliberately left untouched by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
